// File: rtl/game_state_ctrl.sv
// Game supervisor: frame-rate collision detect, IDLE/RUN/OVER FSM,
// and a 4-digit BCD score with high score.
module game_state_ctrl #(
  parameter logic [7:0]  START_KEY        = 8'h2C,
  parameter logic [7:0]  CLEAR_KEY        = 8'h28,
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned COLLIDE_THRESH   = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        is_ball,
  input  logic        is_tree,
  input  logic [7:0]  keycode,
  output logic [1:0]  state,
  output logic        run_enable,
  output logic        restart,
  output logic        game_over,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
  localparam logic [1:0] S_BAD  = 2'd3;

  localparam logic [7:0] FPP_LAST = 8'(FRAMES_PER_POINT - 1);
  localparam logic [7:0] THRESH   = 8'(COLLIDE_THRESH);

  logic        fc_cur_q, fc_prev_q, tick_q;
  logic [7:0]  ovl_q, ovl_d;
  logic [7:0]  frm_q, frm_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic        restart_q, restart_d;
  logic        ovl_now, collide;

  // Per-digit BCD increment; 9999 holds rather than wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign ovl_now = is_ball && is_tree &&
                   (DrawX < 10'd640) && (DrawY < 10'd480);
  assign collide = (ovl_q >= THRESH);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_cur_q  <= 1'b0;
      fc_prev_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      fc_cur_q  <= frame_clk;
      fc_prev_q <= fc_cur_q;
      tick_q    <= fc_cur_q && !fc_prev_q;
    end
  end

  // Compared on the tick, then reloaded with the tick cycle's own overlap.
  always_comb begin
    ovl_d = ovl_q;
    if (tick_q) begin
      ovl_d = ovl_now ? 8'd1 : 8'd0;
    end else if (ovl_now && (ovl_q != 8'hFF)) begin
      ovl_d = ovl_q + 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    high_d    = high_q;
    frm_d     = frm_q;
    restart_d = 1'b0;
    if (state_q == S_BAD) begin
      state_d = S_IDLE;
    end else if (tick_q) begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (keycode == START_KEY) begin
            state_d   = S_RUN;
            restart_d = 1'b1;
            score_d   = 16'h0000;
            frm_d     = 8'd0;
          end
        end
        (state_q == S_RUN): begin
          if (collide) begin
            state_d = S_OVER;
            if (score_q > high_q) begin
              high_d = score_q;
            end
          end else if (frm_q == FPP_LAST) begin
            frm_d   = 8'd0;
            score_d = bcd_inc(score_q);
          end else begin
            frm_d = frm_q + 8'd1;
          end
        end
        (state_q == S_OVER): begin
          if (keycode == CLEAR_KEY) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovl_q     <= 8'd0;
      frm_q     <= 8'd0;
      state_q   <= S_IDLE;
      score_q   <= 16'h0000;
      high_q    <= 16'h0000;
      restart_q <= 1'b0;
    end else begin
      ovl_q     <= ovl_d;
      frm_q     <= frm_d;
      state_q   <= state_d;
      score_q   <= score_d;
      high_q    <= high_d;
      restart_q <= restart_d;
    end
  end

  assign state      = state_q;
  assign run_enable = (state_q == S_RUN);
  assign game_over  = (state_q == S_OVER);
  assign restart    = restart_q;
  assign score_bcd  = score_q;
  assign high_bcd   = high_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a per-tick expectation queue
// driven by a small decimal-score reference model.
module tb_game_state_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        fclk_a, fclk_b;
  logic [9:0]  DrawX, DrawY;
  logic        is_ball, is_tree;
  logic [7:0]  keycode;

  logic [1:0]  st_a, st_b;
  logic        re_a, re_b, rs_a, rs_b, go_a, go_b;
  logic [15:0] sc_a, sc_b, hi_a, hi_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] hi;
    logic        rs;
  } exp_t;

  exp_t q[$];

  int m_st[2], m_sc[2], m_hi[2], m_frm[2];
  int fpp[2] = '{6, 1};

  always #5 Clk = ~Clk;

  game_state_ctrl u_a (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(fclk_a),
    .DrawX(DrawX), .DrawY(DrawY),
    .is_ball(is_ball), .is_tree(is_tree), .keycode(keycode),
    .state(st_a), .run_enable(re_a), .restart(rs_a),
    .game_over(go_a), .score_bcd(sc_a), .high_bcd(hi_a)
  );

  game_state_ctrl #(.FRAMES_PER_POINT(1)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(fclk_b),
    .DrawX(DrawX), .DrawY(DrawY),
    .is_ball(is_ball), .is_tree(is_tree), .keycode(keycode),
    .state(st_b), .run_enable(re_b), .restart(rs_b),
    .game_over(go_b), .score_bcd(sc_b), .high_bcd(hi_b)
  );

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10),
              4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input int b, input int novl, input logic [7:0] key);
    exp_t e;
    e.rs = 1'b0;
    case (m_st[b])
      0: if (key == 8'h2C) begin
           m_st[b] = 1; m_sc[b] = 0; m_frm[b] = 0; e.rs = 1'b1;
         end
      1: if (novl >= 4) begin
           m_st[b] = 2;
           if (m_sc[b] > m_hi[b]) m_hi[b] = m_sc[b];
         end else if (m_frm[b] == fpp[b] - 1) begin
           m_frm[b] = 0;
           if (m_sc[b] < 9999) m_sc[b]++;
         end else begin
           m_frm[b]++;
         end
      default: if (key == 8'h28) m_st[b] = 0;
    endcase
    e.st = 2'(m_st[b]);
    e.sc = to_bcd(m_sc[b]);
    e.hi = to_bcd(m_hi[b]);
    q.push_back(e);
  endtask

  task automatic set_ovl(input logic bl, input logic tr, input logic [9:0] x);
    is_ball = bl; is_tree = tr; DrawX = x; DrawY = 10'd100;
  endtask

  // novl in-range overlap cycles, noob overlap cycles off-screen, then one tick
  task automatic do_tick(input int b, input int novl, input int noob,
                         input logic [7:0] key);
    exp_t e;
    for (int i = 0; i < novl; i++) begin
      @(negedge Clk); set_ovl(1'b1, 1'b1, 10'd100);
    end
    for (int i = 0; i < noob; i++) begin
      @(negedge Clk); set_ovl(1'b1, 1'b1, 10'd640);
    end
    @(negedge Clk); set_ovl(1'b0, 1'b0, 10'd0);
    model(b, novl, key);
    keycode = key;
    if (b == 1) fclk_b = 1'b1; else fclk_a = 1'b1;
    @(negedge Clk); fclk_a = 1'b0; fclk_b = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    keycode = 8'h00;
    if (q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      if (b == 1) begin
        check("b_state", 32'(st_b), 32'(e.st));
        check("b_score", 32'(sc_b), 32'(e.sc));
        check("b_high", 32'(hi_b), 32'(e.hi));
        check("b_restart", 32'(rs_b), 32'(e.rs));
        check("b_run_en", 32'(re_b), 32'(e.st == 2'd1));
      end else begin
        check("a_state", 32'(st_a), 32'(e.st));
        check("a_score", 32'(sc_a), 32'(e.sc));
        check("a_high", 32'(hi_a), 32'(e.hi));
        check("a_restart", 32'(rs_a), 32'(e.rs));
        check("a_run_en", 32'(re_a), 32'(e.st == 2'd1));
        check("a_game_over", 32'(go_a), 32'(e.st == 2'd2));
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_sc[i] = 0; m_hi[i] = 0; m_frm[i] = 0;
    end
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_st"}, 32'(st_a), 32'd0);
    check({tag, "_re"}, 32'(re_a), 32'd0);
    check({tag, "_rs"}, 32'(rs_a), 32'd0);
    check({tag, "_go"}, 32'(go_a), 32'd0);
    check({tag, "_sc"}, 32'(sc_a), 32'd0);
    check({tag, "_hi"}, 32'(hi_a), 32'd0);
    check({tag, "_b_sc"}, 32'(sc_b), 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    fclk_a = 1'b0; fclk_b = 1'b0;
    keycode = 8'h00;
    set_ovl(1'b0, 1'b0, 10'd0);
    model_reset();
    #1;
    check_zero("reset_async");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_zero("reset_rel");

    // FRAMES_PER_POINT=1 instance: BCD carries and 9999 saturation
    do_tick(1, 0, 0, 8'h2C);
    for (int k = 1; k <= 10004; k++) begin
      do_tick(1, 0, 0, 8'h00);
      if (k == 99)    check("b_99", 32'(sc_b), 32'h0099);
      if (k == 100)   check("b_100", 32'(sc_b), 32'h0100);
      if (k == 9999)  check("b_9999", 32'(sc_b), 32'h9999);
      if (k == 10004) check("b_sat", 32'(sc_b), 32'h9999);
    end

    for (int k = 0; k < 10; k++) do_tick(0, 0, 0, 8'h00);
    check("idle_state", 32'(st_a), 32'd0);

    do_tick(0, 0, 0, 8'h2C);
    check("start_rs", 32'(rs_a), 32'd1);
    @(negedge Clk);
    check("start_rs_1clk", 32'(rs_a), 32'd0);
    for (int k = 0; k < 6; k++) do_tick(0, 0, 0, 8'h00);
    check("score_6", 32'(sc_a), 32'h0001);
    for (int k = 0; k < 54; k++) do_tick(0, 0, 0, 8'h00);
    check("score_60", 32'(sc_a), 32'h0010);

    do_tick(0, 3, 6, 8'h00);
    check("ovl3_run", 32'(st_a), 32'd1);
    do_tick(0, 4, 0, 8'h00);
    check("ovl4_over", 32'(st_a), 32'd2);
    check("ovl4_high", 32'(hi_a), 32'(sc_a));

    do_tick(0, 0, 0, 8'h2C);
    check("over_start_ign", 32'(st_a), 32'd2);
    do_tick(0, 0, 0, 8'h28);
    check("clear_idle", 32'(st_a), 32'd0);
    check("clear_high", 32'(hi_a), 32'h0010);

    // Second game: collide on what would be a point tick, lower score
    do_tick(0, 0, 0, 8'h2C);
    for (int k = 0; k < 17; k++) do_tick(0, 0, 0, 8'h00);
    check("g2_pre", 32'(sc_a), 32'h0002);
    do_tick(0, 5, 0, 8'h00);
    check("g2_over", 32'(st_a), 32'd2);
    check("g2_score", 32'(sc_a), 32'h0002);
    check("g2_high", 32'(hi_a), 32'h0010);
    do_tick(0, 0, 0, 8'h28);

    do_tick(0, 0, 0, 8'h2C);
    for (int k = 0; k < 7; k++) do_tick(0, 0, 0, 8'h00);
    check("g3_run", 32'(st_a), 32'd1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check_zero("reset_mid");
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);
    check("rel_state", 32'(st_a), 32'd0);
    check("rel_high", 32'(hi_a), 32'h0000);
    do_tick(0, 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
